// File: rtl/hangman_reveal_board_if.sv
// Bus between the guess-entry logic and the hangman reveal board.
// The dup/used_letters signals exist only when GUESS_HISTORY_EN is defined.
interface hangman_reveal_board_if #(
   parameter int NUM_SLOTS = 6,
   parameter int CHAR_W    = 5
);
   logic                          start;
   logic [NUM_SLOTS*CHAR_W-1:0]   word;
   logic                          guess_valid;
   logic [CHAR_W-1:0]             guess;
   logic                          ready;
   logic [NUM_SLOTS*CHAR_W-1:0]   display;
   logic [NUM_SLOTS-1:0]          revealed;
   logic [3:0]                    miss_count;
   logic                          hit;
   logic                          miss;
   logic                          win;
   logic                          lose;
`ifdef GUESS_HISTORY_EN
   logic                          dup;
   logic [(1<<CHAR_W)-1:0]        used_letters;

   modport master (
      output start, word, guess_valid, guess,
      input  ready, display, revealed, miss_count, hit, miss, win, lose, dup, used_letters
   );
   modport slave (
      input  start, word, guess_valid, guess,
      output ready, display, revealed, miss_count, hit, miss, win, lose, dup, used_letters
   );
`else
   modport master (
      output start, word, guess_valid, guess,
      input  ready, display, revealed, miss_count, hit, miss, win, lose
   );
   modport slave (
      input  start, word, guess_valid, guess,
      output ready, display, revealed, miss_count, hit, miss, win, lose
   );
`endif
endinterface

// File: rtl/hangman_reveal_board.sv
// Synchronous hangman letter-reveal board: parallel slot compare, miss counting, win/lose.
// Optional macro GUESS_HISTORY_EN adds a used-letter vector and a dup pulse for repeated guesses.
module hangman_reveal_board #(
   parameter int               NUM_SLOTS  = 6,
   parameter int               CHAR_W     = 5,
   parameter int               MAX_MISSES = 6,
   parameter logic [CHAR_W-1:0] BLANK     = {CHAR_W{1'b1}}
) (
   input logic                   clk,
   input logic                   resetn,
   hangman_reveal_board_if.slave bus
);
   localparam int         WORD_W     = NUM_SLOTS * CHAR_W;
   localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISSES);

   typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

   state_t               state;
   logic [WORD_W-1:0]    stored;
   logic [WORD_W-1:0]    display_r;
   logic [NUM_SLOTS-1:0] revealed_r;
   logic [3:0]           count_r;
   logic                 hit_r;
   logic                 miss_r;
   logic                 win_r;
   logic                 lose_r;
   logic                 ready_r;

   logic [NUM_SLOTS-1:0] match;
   logic [NUM_SLOTS-1:0] unused_mask;
   logic [NUM_SLOTS-1:0] merged;
   logic [WORD_W-1:0]    merged_display;
   logic [3:0]           miss_inc;
   logic                 accept;
   logic                 scoring;

`ifdef GUESS_HISTORY_EN
   logic [(1<<CHAR_W)-1:0] used_r;
   logic                   dup_r;
   logic                   dup_hit;
`endif

   // Compare the guess against every slot at once and precompute the post-hit display.
   always_comb begin
      match          = '0;
      unused_mask    = '0;
      merged_display = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         match[i]       = (stored[i*CHAR_W +: CHAR_W] == bus.guess) &&
                          (stored[i*CHAR_W +: CHAR_W] != BLANK);
         unused_mask[i] = (bus.word[i*CHAR_W +: CHAR_W] == BLANK);
      end
      merged = revealed_r | match;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         merged_display[i*CHAR_W +: CHAR_W] = merged[i] ? stored[i*CHAR_W +: CHAR_W] : BLANK;
      end
      miss_inc = (count_r < MISS_LIMIT) ? count_r + 4'd1 : count_r;
      accept   = bus.guess_valid && ready_r && (bus.guess != BLANK);
`ifdef GUESS_HISTORY_EN
      dup_hit  = used_r[bus.guess];
      scoring  = accept && !dup_hit;
`else
      scoring  = accept;
`endif
   end

   // Round FSM; ready drops on the guess that finishes the round, state follows one cycle later.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         stored     <= {NUM_SLOTS{BLANK}};
         display_r  <= {NUM_SLOTS{BLANK}};
         revealed_r <= '0;
         count_r    <= '0;
         hit_r      <= 1'b0;
         miss_r     <= 1'b0;
         win_r      <= 1'b0;
         lose_r     <= 1'b0;
         ready_r    <= 1'b0;
`ifdef GUESS_HISTORY_EN
         used_r     <= '0;
         dup_r      <= 1'b0;
`endif
      end else begin
         hit_r  <= 1'b0;
         miss_r <= 1'b0;
`ifdef GUESS_HISTORY_EN
         dup_r  <= 1'b0;
`endif
         if (bus.start) begin
            state      <= PLAY;
            stored     <= bus.word;
            display_r  <= {NUM_SLOTS{BLANK}};
            revealed_r <= unused_mask;
            count_r    <= '0;
            win_r      <= 1'b0;
            lose_r     <= 1'b0;
            ready_r    <= ~&unused_mask;
`ifdef GUESS_HISTORY_EN
            used_r     <= '0;
`endif
         end else if (state == PLAY) begin
            if (&revealed_r) begin
               state   <= WIN;
               win_r   <= 1'b1;
               ready_r <= 1'b0;
            end else if (count_r >= MISS_LIMIT) begin
               state      <= LOSE;
               lose_r     <= 1'b1;
               ready_r    <= 1'b0;
               revealed_r <= '1;
               display_r  <= stored;
            end else begin
`ifdef GUESS_HISTORY_EN
               if (accept && dup_hit) begin
                  dup_r <= 1'b1;
               end
               if (scoring) begin
                  used_r[bus.guess] <= 1'b1;
               end
`endif
               if (scoring) begin
                  if (|match) begin
                     revealed_r <= merged;
                     display_r  <= merged_display;
                     hit_r      <= 1'b1;
                     ready_r    <= ~&merged;
                  end else begin
                     count_r <= miss_inc;
                     miss_r  <= 1'b1;
                     ready_r <= (miss_inc < MISS_LIMIT);
                  end
               end
            end
         end
      end
   end

   assign bus.ready      = ready_r;
   assign bus.display    = display_r;
   assign bus.revealed   = revealed_r;
   assign bus.miss_count = count_r;
   assign bus.hit        = hit_r;
   assign bus.miss       = miss_r;
   assign bus.win        = win_r;
   assign bus.lose       = lose_r;
`ifdef GUESS_HISTORY_EN
   assign bus.dup          = dup_r;
   assign bus.used_letters = used_r;
`endif
endmodule

// File: tb/tb_hangman_reveal_board.sv
// Self-checking bench for hangman_reveal_board: directed game scenarios plus random rounds
// checked against a slot/letter-level game model (honours GUESS_HISTORY_EN when defined).
module tb_hangman_reveal_board;
   localparam int          NS    = 6;
   localparam int          CW    = 5;
   localparam int          MAXM  = 6;
   localparam logic [4:0]  BLK   = 5'h1F;

   logic clk;
   logic resetn;
   int   total;
   int   bad;

   hangman_reveal_board_if #(.NUM_SLOTS(NS), .CHAR_W(CW)) bus ();

   hangman_reveal_board #(
      .NUM_SLOTS(NS), .CHAR_W(CW), .MAX_MISSES(MAXM), .BLANK(BLK)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Game model: letters per slot, which are open, miss tally, phase 0=idle 1=play 2=win 3=lose.
   logic [4:0] m_code [NS];
   bit         m_open [NS];
   int         m_misses;
   int         m_phase;
   bit         m_hit;
   bit         m_miss;
`ifdef GUESS_HISTORY_EN
   bit         m_used [32];
   bit         m_dup;
`endif

   function automatic bit all_open();
      for (int i = 0; i < NS; i++) if (!m_open[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [29:0] pack6(input int a0, a1, a2, a3, a4, a5);
      logic [4:0] s [6];
      logic [29:0] w;
      s[0] = 5'(a0); s[1] = 5'(a1); s[2] = 5'(a2);
      s[3] = 5'(a3); s[4] = 5'(a4); s[5] = 5'(a5);
      for (int i = 0; i < 6; i++) w[i*5 +: 5] = s[i];
      return w;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin m_code[i] = BLK; m_open[i] = 1'b0; end
      m_misses = 0; m_phase = 0; m_hit = 0; m_miss = 0;
`ifdef GUESS_HISTORY_EN
      for (int i = 0; i < 32; i++) m_used[i] = 1'b0;
      m_dup = 0;
`endif
   endtask

   task automatic model_start(input logic [29:0] w);
      for (int i = 0; i < NS; i++) begin
         m_code[i] = w[i*5 +: 5];
         m_open[i] = (m_code[i] == BLK);
      end
      m_misses = 0; m_phase = 1; m_hit = 0; m_miss = 0;
`ifdef GUESS_HISTORY_EN
      for (int i = 0; i < 32; i++) m_used[i] = 1'b0;
      m_dup = 0;
`endif
   endtask

   task automatic model_guess(input logic [4:0] g);
      bit found;
      m_hit = 0; m_miss = 0;
`ifdef GUESS_HISTORY_EN
      m_dup = 0;
`endif
      if (m_phase != 1 || all_open() || m_misses >= MAXM || g == BLK) return;
`ifdef GUESS_HISTORY_EN
      if (m_used[g]) begin m_dup = 1; return; end
      m_used[g] = 1'b1;
`endif
      found = 0;
      for (int i = 0; i < NS; i++) if (m_code[i] == g) begin m_open[i] = 1'b1; found = 1; end
      if (found) m_hit = 1;
      else begin
         m_miss = 1;
         if (m_misses < MAXM) m_misses++;
      end
   endtask

   task automatic model_settle();
      m_hit = 0; m_miss = 0;
`ifdef GUESS_HISTORY_EN
      m_dup = 0;
`endif
      if (m_phase == 1) begin
         if (all_open()) m_phase = 2;
         else if (m_misses >= MAXM) begin
            m_phase = 3;
            for (int i = 0; i < NS; i++) m_open[i] = 1'b1;
         end
      end
   endtask

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic check_output(input string tag);
      logic [29:0] exp_disp;
      logic [5:0]  exp_rev;
      for (int i = 0; i < NS; i++) begin
         exp_disp[i*5 +: 5] = m_open[i] ? m_code[i] : BLK;
         exp_rev[i]         = m_open[i];
      end
      check_val({tag, ".display"},    32'(bus.display),    32'(exp_disp));
      check_val({tag, ".revealed"},   32'(bus.revealed),   32'(exp_rev));
      check_val({tag, ".miss_count"}, 32'(bus.miss_count), 32'(m_misses));
      check_val({tag, ".hit"},        32'(bus.hit),        32'(m_hit));
      check_val({tag, ".miss"},       32'(bus.miss),       32'(m_miss));
      check_val({tag, ".ready"},      32'(bus.ready),
                32'(m_phase == 1 && !all_open() && m_misses < MAXM));
      check_val({tag, ".win"},        32'(bus.win),        32'(m_phase == 2));
      check_val({tag, ".lose"},       32'(bus.lose),       32'(m_phase == 3));
`ifdef GUESS_HISTORY_EN
      begin
         logic [31:0] exp_used;
         for (int i = 0; i < 32; i++) exp_used[i] = m_used[i];
         check_val({tag, ".dup"},          32'(bus.dup),  32'(m_dup));
         check_val({tag, ".used_letters"}, bus.used_letters, exp_used);
      end
`endif
   endtask

   task automatic apply_stimulus_start(input logic [29:0] w, input bit with_guess,
                                       input logic [4:0] g, input string tag);
      @(negedge clk);
      bus.start = 1'b1; bus.word = w;
      bus.guess_valid = with_guess; bus.guess = g;
      @(negedge clk);
      bus.start = 1'b0; bus.guess_valid = 1'b0;
      model_start(w);
      check_output(tag);
      model_settle();
      @(negedge clk);
      check_output({tag, ".settle"});
   endtask

   task automatic apply_stimulus_guess(input logic [4:0] g, input string tag);
      @(negedge clk);
      bus.guess_valid = 1'b1; bus.guess = g;
      @(negedge clk);
      bus.guess_valid = 1'b0;
      model_guess(g);
      check_output(tag);
      model_settle();
      @(negedge clk);
      check_output({tag, ".settle"});
   endtask

   // Watchdog so a stuck simulation still reports and stops.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [29:0] hangmn;
      logic [29:0] rw;
      int          codes [6];
      total = 0; bad = 0;
      hangmn = pack6(7, 0, 13, 6, 12, 13);
      resetn = 1'b0;
      bus.start = 1'b0; bus.word = '0; bus.guess_valid = 1'b0; bus.guess = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_output("reset");
      resetn = 1'b1;
      apply_stimulus_guess(5'd7, "idle_guess");

      apply_stimulus_start(hangmn, 1'b0, 5'd0, "start1");
      apply_stimulus_guess(5'd13, "multi_reveal");
      apply_stimulus_guess(5'd7, "pre_reset");

      @(negedge clk);
      #2 resetn = 1'b0;
      #1 model_reset();
      check_output("midround_reset");
      @(negedge clk);
      resetn = 1'b1;

      apply_stimulus_start(hangmn, 1'b0, 5'd0, "start_lose");
      foreach (codes[i]) codes[i] = 0;
      apply_stimulus_guess(5'd1, "lose_g1");
      apply_stimulus_guess(5'd2, "lose_g2");
      apply_stimulus_guess(5'd3, "lose_g3");
      apply_stimulus_guess(5'd4, "lose_g4");
      apply_stimulus_guess(5'd5, "lose_g5");
      apply_stimulus_guess(5'd8, "lose_g6");
      apply_stimulus_guess(5'd7, "lose_ignored");

      apply_stimulus_start(hangmn, 1'b0, 5'd0, "start_win");
      apply_stimulus_guess(5'd7,  "win_g7");
      apply_stimulus_guess(5'd0,  "win_g0");
      apply_stimulus_guess(5'd13, "win_g13");
      apply_stimulus_guess(5'd6,  "win_g6");
      apply_stimulus_guess(5'd12, "win_g12");
      apply_stimulus_guess(5'd9,  "win_ignored");

      apply_stimulus_start(pack6(3, 31, 31, 31, 31, 31), 1'b0, 5'd0, "start_single");
      apply_stimulus_guess(5'd31, "blank_guess");
      apply_stimulus_guess(5'd3,  "single_win");

      apply_stimulus_start(pack6(31, 31, 31, 31, 31, 31), 1'b0, 5'd0, "all_blank");

      apply_stimulus_start(pack6(7, 0, 31, 6, 31, 13), 1'b1, 5'd7, "collision");
      apply_stimulus_guess(5'd1, "repeat_first");
      apply_stimulus_guess(5'd1, "repeat_second");
      apply_stimulus_guess(5'd0, "repeat_hit1");
      apply_stimulus_guess(5'd0, "repeat_hit2");

      // Random rounds over a small alphabet so hits, repeats and both endings all occur.
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 6; i++)
            codes[i] = ($urandom_range(0, 4) == 0) ? 31 : int'($urandom_range(0, 9));
         rw = pack6(codes[0], codes[1], codes[2], codes[3], codes[4], codes[5]);
         apply_stimulus_start(rw, 1'b0, 5'd0, $sformatf("rnd%0d.start", r));
         for (int k = 0; k < 14; k++) begin
            logic [4:0] g;
            g = ($urandom_range(0, 7) == 0) ? BLK : 5'($urandom_range(0, 11));
            apply_stimulus_guess(g, $sformatf("rnd%0d.g%0d", r, k));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
